// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory request front-end, the memory block and the bench.
package mem_pkg;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 2048;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP
    } mem_ctrl_state_e;
endpackage

// File: rtl/mem_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module mem_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for the single-port memory: sequences the memory pins per request,
// captures registered read data and returns one response per accepted request.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_enb,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output mem_ctrl_state_e   dbg_state
);
    // Valid/ready: a transfer happens on a rising edge where both are high; valid
    // and its payload hold until that edge, and ready never depends on valid.

    // One extra bit so MEM_DEPTH == 2**ADDR_W never flags an address.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    mem_ctrl_state_e state;
    logic            addr_err;
    logic            wr_inc;
    logic            rd_inc;
    logic            err_inc;

    assign addr_err  = {1'b0, req_addr} >= DEPTH_L;
    assign wr_inc    = (state == WR);
    assign rd_inc    = (state == RD_DATA);
    assign err_inc   = (state == RESP) && rsp_ready && rsp_err;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_wr      <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_enb     <= 1'b0;
            mem_rd_wr   <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        mem_addr    <= req_addr;
                        mem_data_in <= req_wdata;
                        rsp_wr      <= req_wr;
                        if (addr_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_wr) begin
                            state     <= WR;
                            mem_enb   <= 1'b1;
                            mem_rd_wr <= 1'b0;
                        end else begin
                            state     <= RD_ADDR;
                            mem_enb   <= 1'b1;
                            mem_rd_wr <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state     <= RESP;
                    mem_enb   <= 1'b0;
                    mem_rd_wr <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_wr    <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    // Memory output is only driven while enb & rd_wr stay high this cycle.
                    state     <= RESP;
                    mem_enb   <= 1'b0;
                    mem_rd_wr <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_wr    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= mem_data_out;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    mem_enb   <= 1'b0;
                    mem_rd_wr <= 1'b1;
                end
            endcase
        end
    end

    mem_sat_cnt #(.W(CNT_W)) u_wr_cnt (.clk(clk), .rst_n(rst_n), .inc(wr_inc),  .count(wr_cnt));
    mem_sat_cnt #(.W(CNT_W)) u_rd_cnt (.clk(clk), .rst_n(rst_n), .inc(rd_inc),  .count(rd_cnt));
    mem_sat_cnt #(.W(CNT_W)) u_er_cnt (.clk(clk), .rst_n(rst_n), .inc(err_inc), .count(err_cnt));
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port memory (registered, tri-stated output).
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = DEF_MEM_DEPTH;
    localparam int MA    = $clog2(DEPTH);
    localparam int CW    = 4;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_wr;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_enb;
    logic            mem_rd_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_in;
    wire  [DW-1:0]   mem_data_out;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   err_cnt;
    mem_ctrl_state_e dbg_state;

    int              n_assert;
    int              n_fail;
    int              enb_cycles;
    logic            r_wr;
    logic            r_err;
    logic [DW-1:0]   r_rdata;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT ----------------
    mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_enb(mem_enb), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_q <= '0;
        end else if (mem_enb) begin
            if (mem_rd_wr) mem_q <= mem[mem_addr[MA-1:0]];
            else           mem[mem_addr[MA-1:0]] <= mem_data_in;
        end
    end

    assign mem_data_out = (mem_enb && mem_rd_wr && rst_n) ? mem_q : {DW{1'bz}};

    always @(negedge clk) if (mem_enb === 1'b1) enb_cycles++;

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output time t_acc);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk1("accept_seen", ok, 1'b1);
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
            lat++;
        end
        chk1("rsp_seen", ok, 1'b1);
        r_wr = rsp_wr; r_err = rsp_err; r_rdata = rsp_rdata;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output time t_acc, output int lat);
        send(wr, a, d, t_acc);
        get_rsp(lat);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time t, t_prev;
        int  lat, e0;

        n_assert = 0; n_fail = 0; enb_cycles = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_mem_enb", mem_enb, 1'b0);
        chk1("rst_mem_rd_wr", mem_rd_wr, 1'b1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // write then read back
        e0 = enb_cycles;
        txn(1'b1, 16'h0005, 32'hDEAD_BEEF, t, lat);
        chk("wr_lat", 32'(lat), 32'd1);
        chk1("wr_rsp_wr", r_wr, 1'b1);
        chk1("wr_rsp_err", r_err, 1'b0);
        chk("wr_rsp_rdata", r_rdata, 32'd0);
        chk("wr_enb_cycles", 32'(enb_cycles - e0), 32'd1);
        chk("wr_cnt_1", 32'(wr_cnt), 32'd1);
        e0 = enb_cycles;
        txn(1'b0, 16'h0005, 32'h0, t, lat);
        chk("rd_lat", 32'(lat), 32'd2);
        chk1("rd_rsp_wr", r_wr, 1'b0);
        chk1("rd_rsp_err", r_err, 1'b0);
        chk("rd_rsp_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("rd_enb_cycles", 32'(enb_cycles - e0), 32'd2);
        chk("rd_cnt_1", 32'(rd_cnt), 32'd1);

        // out-of-range address
        e0 = enb_cycles;
        txn(1'b0, 16'h0800, 32'h0, t, lat);
        chk("err_lat", 32'(lat), 32'd0);
        chk1("err_rsp_err", r_err, 1'b1);
        chk("err_rsp_rdata", r_rdata, 32'd0);
        chk("err_enb_cycles", 32'(enb_cycles - e0), 32'd0);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        chk("err_rd_cnt", 32'(rd_cnt), 32'd1);

        // response back-pressure
        rsp_ready = 1'b0;
        send(1'b0, 16'h0005, 32'h0, t);
        get_rsp(lat);
        chk("stall_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk1("stall_req_ready", req_ready, 1'b0);
            chk1("stall_mem_enb", mem_enb, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        chk1("stall_done_valid", rsp_valid, 1'b0);
        chk1("stall_done_ready", req_ready, 1'b1);
        chk("stall_rd_cnt", 32'(rd_cnt), 32'd2);

        // back-to-back writes and reads
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, AW'(i), DW'(i * 3), t, lat);
            if (i > 0) chk("wr_spacing", 32'((t - t_prev) / 10), 32'd3);
            t_prev = t;
        end
        chk("b2b_wr_cnt", 32'(wr_cnt), 32'd9);
        for (int i = 0; i < 8; i++) begin
            txn(1'b0, AW'(i), 32'h0, t, lat);
            chk("b2b_rd_data", r_rdata, 32'(i * 3));
            if (i > 0) chk("rd_spacing", 32'((t - t_prev) / 10), 32'd4);
            t_prev = t;
        end
        chk("b2b_rd_cnt", 32'(rd_cnt), 32'd10);

        // reset during RD_DATA
        txn(1'b1, 16'h0009, 32'h0000_1234, t, lat);
        send(1'b0, 16'h0009, 32'h0, t);
        @(posedge clk) #1;
        chk("mid_state", 32'(dbg_state), 32'(RD_DATA));
        rst_n = 1'b0;
        @(posedge clk) #1;
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_rst_req_ready", req_ready, 1'b1);
        chk1("mid_rst_mem_enb", mem_enb, 1'b0);
        chk1("mid_rst_mem_rd_wr", mem_rd_wr, 1'b1);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk) #1;
        txn(1'b0, 16'h0009, 32'h0, t, lat);
        chk("post_rst_rdata", r_rdata, 32'd0);
        chk("post_rst_rd_cnt", 32'(rd_cnt), 32'd1);

        // saturation of the 4-bit write counter
        for (int i = 0; i < 17; i++) begin
            txn(1'b1, AW'(100 + i), DW'(i), t, lat);
            if (i == 14) chk("sat_wr_cnt_15", 32'(wr_cnt), 32'd15);
        end
        chk("sat_wr_cnt_17", 32'(wr_cnt), 32'd15);
        chk("sat_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
